reg_file: RTL

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file.sv | 89 ++++++++
 1 files changed

// File: rtl/reg_file.sv
// Register file with combinational dual read, write bypass, hardwired r0 and a
// sequential clear engine that zeroes r1..rN-1 one register per cycle.
module reg_file #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b,
  input  logic                  clear_start,
  output logic                  busy
);
  localparam int NREGS = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   regs_q [NREGS];
  logic                    wr_ok;

  assign wr_ok = write_enable && !busy && (write_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= ADDR_WIDTH'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter parks at 1 on exit so it never points at r0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = ADDR_WIDTH'(1);
        end
      end
      CLEAR: begin
        if (cnt_q == '1) begin
          state_d = IDLE;
          cnt_d   = ADDR_WIDTH'(1);
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CLEAR);
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign regs_q[gi] = '0;
    end else begin : g_store
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          regs_q[gi] <= '0;
        else if (busy && cnt_q == ADDR_WIDTH'(gi))
          regs_q[gi] <= '0;
        else if (wr_ok && write_addr == ADDR_WIDTH'(gi))
          regs_q[gi] <= write_data;
      end
    end
  end

  always_comb begin
    read_data_a = regs_q[read_addr_a];
    read_data_b = regs_q[read_addr_b];
    if (wr_ok && write_addr == read_addr_a) read_data_a = write_data;
    if (wr_ok && write_addr == read_addr_b) read_data_b = write_data;
  end

endmodule
